// File: rtl/yolo_params_pkg.sv
// Shared convolution geometry plus the element, matrix and FSM types used by
// the ofmap read-out path.
package yolo_params_pkg;

  localparam int IP_DATA_WIDTH = 8;
  localparam int IFMAP_SIZE    = 5;
  localparam int FILTER_SIZE   = 3;
  localparam int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1;

  localparam int OP_WIDTH = 2 * IP_DATA_WIDTH + 1;
  localparam int IDX_W    = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;

  typedef logic [OP_WIDTH-1:0] ofmap_elem_t;
  typedef ofmap_elem_t ofmap_t [OFMAP_SIZE][OFMAP_SIZE];
  typedef logic [IDX_W-1:0] ofmap_idx_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } strm_state_e;

  // Highest legal row/column index, sized to the counter width.
  function automatic ofmap_idx_t last_idx();
    return ofmap_idx_t'(OFMAP_SIZE - 1);
  endfunction

endpackage

// File: rtl/ofmap_streamer.sv
// Captures one parallel OFMAP_SIZE x OFMAP_SIZE result matrix and replays it
// row-major, one element per accepted beat, with row/col tags and a last flag.
module ofmap_streamer
  import yolo_params_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  ofmap_t              result_matrix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]    out_row,
  output logic [IDX_W-1:0]    out_col,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output strm_state_e         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_valid/in_ready capture a whole matrix only while idle; once out_valid
  // rises it stays high, with data/tags frozen, until out_ready accepts it.

  strm_state_e state_q, state_d;
  ofmap_t      snapshot_q;
  ofmap_idx_t  row_q, col_q;
  logic        done_q;

  logic capture;
  logic beat;
  logic at_last;

  assign at_last = (row_q == last_idx()) && (col_q == last_idx());
  assign capture = (state_q == IDLE) && in_valid;
  assign beat    = (state_q == STREAM) && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = STREAM;
      STREAM:  if (out_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = snapshot_q[row_q][col_q];
        out_last  = at_last;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // The snapshot is only written on capture, so the source may change freely
  // while the frame drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < OFMAP_SIZE; r++) begin
        for (int c = 0; c < OFMAP_SIZE; c++) begin
          snapshot_q[r][c] <= '0;
        end
      end
    end else if (capture) begin
      snapshot_q <= result_matrix;
    end
  end

  // Row-major walk; wraps back to [0][0] on the last beat so the next frame
  // starts from the origin without an extra clear cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (capture) begin
      row_q <= '0;
      col_q <= '0;
    end else if (beat) begin
      if (col_q == last_idx()) begin
        col_q <= '0;
        row_q <= (row_q == last_idx()) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= beat && at_last;
    end
  end

  assign done      = done_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ofmap_streamer.sv
// Directed and randomized frames through ofmap_streamer, checked against a
// convolution-based reference and a beat-order scoreboard.
module tb_ofmap_streamer;
  import yolo_params_pkg::*;

  localparam int SB_W = 2 * IDX_W + OP_WIDTH + 1;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  ofmap_t              result_matrix;
  logic                out_valid;
  logic                out_ready;
  logic [OP_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]    out_row;
  logic [IDX_W-1:0]    out_col;
  logic                out_last;
  logic                busy;
  logic                done;
  strm_state_e         state_dbg;

  int total;
  int bad;

  logic [SB_W-1:0] exp_q[$];
  int              ifm[IFMAP_SIZE][IFMAP_SIZE];
  int              flt[FILTER_SIZE][FILTER_SIZE];
  ofmap_t          ref_m;
  ofmap_t          junk_m;

  ofmap_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .result_matrix (result_matrix),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: valid 2-D convolution with plain integer arithmetic, kept to OP_WIDTH bits.
  task automatic build_conv();
    int acc;
    for (int r = 0; r < OFMAP_SIZE; r++) begin
      for (int c = 0; c < OFMAP_SIZE; c++) begin
        acc = 0;
        for (int i = 0; i < FILTER_SIZE; i++)
          for (int j = 0; j < FILTER_SIZE; j++)
            acc += ifm[r+i][c+j] * flt[i][j];
        ref_m[r][c] = ofmap_elem_t'(acc);
      end
    end
  endtask

  task automatic fill_const(input logic [OP_WIDTH-1:0] v);
    for (int r = 0; r < OFMAP_SIZE; r++)
      for (int c = 0; c < OFMAP_SIZE; c++)
        ref_m[r][c] = v;
  endtask

  task automatic push_expected();
    logic last;
    for (int r = 0; r < OFMAP_SIZE; r++) begin
      for (int c = 0; c < OFMAP_SIZE; c++) begin
        last = (r == OFMAP_SIZE - 1) && (c == OFMAP_SIZE - 1);
        exp_q.push_back({IDX_W'(r), IDX_W'(c), ref_m[r][c], last});
      end
    end
  endtask

  // Called at posedge+1 while idle; presents ref_m for one capture edge.
  task automatic capture_frame();
    result_matrix = ref_m;
    in_valid      = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_done", done, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // mode 0: ready always; 1: pattern 1,0,0; 2: random. noise pokes in_valid with junk.
  // chain: capture ref_m in the done cycle.
  task automatic drain_frame(input int mode, input bit noise, input bit chain);
    logic [SB_W-1:0] e;
    logic [SB_W-1:0] prev;
    bit              stalled;
    bit              finished;
    int              k;
    stalled  = 0;
    finished = 0;
    k        = 0;
    prev     = '0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      k++;
      if (noise) begin
        in_valid      = ($urandom_range(0, 1) == 1);
        result_matrix = junk_m;
      end
      @(negedge clk);
      check("stream_valid", out_valid, 1);
      check("stream_busy", busy, 1);
      check("stream_in_ready", in_ready, 0);
      check("stream_no_done", done, 0);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
        finished = 1;
      end else begin
        e = exp_q[0];
        check("beat_row", out_row, e[SB_W-1 -: IDX_W]);
        check("beat_col", out_col, e[SB_W-IDX_W-1 -: IDX_W]);
        check("beat_data", out_data, e[OP_WIDTH:1]);
        check("beat_last", out_last, e[0]);
        if (stalled)
          check("stall_hold", {out_row, out_col, out_data, out_last}, prev);
        prev    = {out_row, out_col, out_data, out_last};
        stalled = !out_ready;
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e[0]) finished = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!finished) check("drain_timeout", 0, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (chain) begin
      result_matrix = ref_m;
      in_valid      = 1'b1;
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_no_valid", out_valid, 0);
    check("done_not_busy", busy, 0);
    check("done_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!chain) begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_plan_frame();
    for (int r = 0; r < IFMAP_SIZE; r++)
      for (int c = 0; c < IFMAP_SIZE; c++)
        ifm[r][c] = r * IFMAP_SIZE + c + 1;
    for (int i = 0; i < FILTER_SIZE; i++)
      for (int j = 0; j < FILTER_SIZE; j++)
        flt[i][j] = 2;
    build_conv();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fill_const('0);
    result_matrix = ref_m;
    for (int r = 0; r < OFMAP_SIZE; r++)
      for (int c = 0; c < OFMAP_SIZE; c++)
        junk_m[r][c] = '1;

    rst = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_row_col", {out_row, out_col}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Known frame from the hand-worked example; spot-check two elements.
    load_plan_frame();
    check("ref_first", ref_m[0][0], 126);
    check("ref_last", ref_m[OFMAP_SIZE-1][OFMAP_SIZE-1], 342);
    push_expected();
    capture_frame();
    drain_frame(0, 0, 0);

    // Same frame under a 1,0,0 ready pattern.
    push_expected();
    capture_frame();
    drain_frame(1, 0, 0);

    // Source changes and in_valid pokes while streaming must not disturb it.
    push_expected();
    capture_frame();
    drain_frame(2, 1, 0);

    // Back-to-back: second frame of 7s captured in the done cycle.
    push_expected();
    capture_frame();
    fill_const(OP_WIDTH'(7));
    drain_frame(0, 0, 1);
    push_expected();
    drain_frame(0, 0, 0);

    // Reset after four accepted beats.
    load_plan_frame();
    capture_frame();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_pos", {out_row, out_col}, {IDX_W'(1), IDX_W'(1)});
    check("pre_rst_data", out_data, ref_m[1][1]);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_data", out_data, 0);
    check("async_rst_pos", {out_row, out_col, out_last, busy, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    push_expected();
    capture_frame();
    drain_frame(0, 0, 0);

    // Full-width element: all OP_WIDTH bits set.
    fill_const('1);
    push_expected();
    capture_frame();
    drain_frame(1, 0, 0);

    // Random ifmap/filter frames under random backpressure, some chained.
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < IFMAP_SIZE; r++)
        for (int c = 0; c < IFMAP_SIZE; c++)
          ifm[r][c] = $urandom_range(0, 255);
      for (int i = 0; i < FILTER_SIZE; i++)
        for (int j = 0; j < FILTER_SIZE; j++)
          flt[i][j] = $urandom_range(0, 255);
      build_conv();
      push_expected();
      capture_frame();
      drain_frame(2, (f % 2) == 1, 0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
